// File: rtl/led_step_counter.sv
// Free-running LED counter with a clock-enable prescaler: up/down/bounce/hold
// modes over 0..LIMIT, synchronous load, and registered TICK/WRAP status pulses.
module led_step_counter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             CLK_50M,
  input  logic             RESET,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] LED,
  output logic             TICK,
  output logic             WRAP,
  output logic             o_dbg_dir
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DN   = 2'd1;
  localparam logic [1:0] MODE_BNC  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  // Bounce direction is the only state machine here; exposed on o_dbg_dir.
  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_led;
  logic             r_tick;
  logic             r_wrap;
  dir_t             r_dir;

  logic             w_step;
  logic [WIDTH-1:0] w_led_nxt;
  logic             w_wrap_nxt;
  dir_t             w_dir_nxt;
  logic [WIDTH-1:0] w_load_val;

  always_comb begin
    w_step     = EN && (r_pre == PRE_LAST);
    w_load_val = (LOAD_VAL > LIMIT) ? LIMIT : LOAD_VAL;
    w_led_nxt  = r_led;
    w_wrap_nxt = 1'b0;
    w_dir_nxt  = r_dir;
    case (MODE)
      MODE_UP: begin
        if (r_led >= LIMIT) begin
          w_led_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_led_nxt = r_led + ONE;
        end
      end
      MODE_DN: begin
        if (r_led == '0) begin
          w_led_nxt  = LIMIT;
          w_wrap_nxt = 1'b1;
        end else if (r_led > LIMIT) begin
          // Out of range after LIMIT was lowered: snap to the top silently.
          w_led_nxt = LIMIT;
        end else begin
          w_led_nxt = r_led - ONE;
        end
      end
      MODE_BNC: begin
        if (LIMIT == '0) begin
          w_led_nxt = '0;
        end else if (r_dir == DIR_UP) begin
          if (r_led >= LIMIT) begin
            w_dir_nxt  = DIR_DN;
            w_led_nxt  = LIMIT - ONE;
            w_wrap_nxt = 1'b1;
          end else begin
            w_led_nxt = r_led + ONE;
          end
        end else begin
          if (r_led == '0) begin
            w_dir_nxt  = DIR_UP;
            w_led_nxt  = ONE;
            w_wrap_nxt = 1'b1;
          end else begin
            w_led_nxt = r_led - ONE;
          end
        end
      end
      MODE_HOLD: begin
        w_led_nxt = r_led;
      end
      default: begin
        w_led_nxt = r_led;
      end
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      r_pre  <= '0;
      r_led  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_dir  <= DIR_UP;
    end else begin
      // Any mode other than bounce restarts a later bounce going up.
      if (MODE != MODE_BNC) begin
        r_dir <= DIR_UP;
      end else if (!LOAD && w_step) begin
        r_dir <= w_dir_nxt;
      end

      if (LOAD) begin
        r_led  <= w_load_val;
        r_pre  <= '0;
        r_tick <= 1'b0;
        r_wrap <= 1'b0;
      end else begin
        r_tick <= w_step;
        r_wrap <= w_step && w_wrap_nxt;
        if (w_step) begin
          r_led <= w_led_nxt;
        end
        if (EN) begin
          r_pre <= w_step ? '0 : (r_pre + PRE_ONE);
        end
      end
    end
  end

  assign LED       = r_led;
  assign TICK      = r_tick;
  assign WRAP      = r_wrap;
  assign o_dbg_dir = r_dir;

endmodule

// File: tb/tb_led_step_counter.sv
// Bench for led_step_counter at WIDTH=4, DIV=4: a table of per-step expectations
// fed through a scoreboard queue, then hand-written load/enable/reset sequences.
module tb_led_step_counter;

  localparam int W   = 4;
  localparam int DV  = 4;
  localparam int BUDGET = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] limit;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] led;
  logic         tick;
  logic         wrap;
  logic         dbg_dir;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] limit;
    logic [W-1:0] led;
    logic         wrap;
    logic         dir;
  } step_t;

  step_t vec[$];
  logic [W+1:0] exp_q[$];

  led_step_counter #(.WIDTH(W), .DIV(DV)) dut (
    .CLK_50M   (clk),
    .RESET     (reset),
    .EN        (en),
    .MODE      (mode),
    .LIMIT     (limit),
    .LOAD      (load),
    .LOAD_VAL  (load_val),
    .LED       (led),
    .TICK      (tick),
    .WRAP      (wrap),
    .o_dbg_dir (dbg_dir)
  );

  // Clock and sampling point: outputs are read 1 time unit after each rising edge.
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < BUDGET);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  function automatic void add(input logic [1:0] m, input int lim, input int l,
                              input logic w, input logic d);
    step_t s;
    s.mode  = m;
    s.limit = W'(lim);
    s.led   = W'(l);
    s.wrap  = w;
    s.dir   = d;
    vec.push_back(s);
  endfunction

  initial begin
    int n;
    logic [W+1:0] got;
    logic bad;

    // Up over the full range, legacy roll-over
    for (int i = 1; i <= 15; i++) add(2'd0, 15, i, 1'b0, 1'b0);
    add(2'd0, 15, 0, 1'b1, 1'b0);
    // Down from 0 with LIMIT=5
    add(2'd1, 5, 5, 1'b1, 1'b0);
    for (int i = 4; i >= 0; i--) add(2'd1, 5, i, 1'b0, 1'b0);
    add(2'd1, 5, 5, 1'b1, 1'b0);
    // Up with LIMIT=0: forced to 0, wrap every step
    add(2'd0, 0, 0, 1'b1, 1'b0);
    add(2'd0, 0, 0, 1'b1, 1'b0);
    // Bounce with LIMIT=3 from 0
    add(2'd2, 3, 1, 1'b0, 1'b0);
    add(2'd2, 3, 2, 1'b0, 1'b0);
    add(2'd2, 3, 3, 1'b0, 1'b0);
    add(2'd2, 3, 2, 1'b1, 1'b1);
    add(2'd2, 3, 1, 1'b0, 1'b1);
    add(2'd2, 3, 0, 1'b0, 1'b1);
    add(2'd2, 3, 1, 1'b1, 1'b0);
    add(2'd2, 3, 2, 1'b0, 1'b0);
    add(2'd2, 3, 3, 1'b0, 1'b0);
    add(2'd2, 3, 2, 1'b1, 1'b1);
    add(2'd2, 3, 1, 1'b0, 1'b1);
    // Leave bounce while going down: continues upward
    add(2'd0, 3, 2, 1'b0, 1'b0);
    add(2'd0, 3, 3, 1'b0, 1'b0);
    add(2'd0, 3, 0, 1'b1, 1'b0);
    // Climb to 8, then down with LIMIT lowered below LED
    for (int i = 1; i <= 8; i++) add(2'd0, 9, i, 1'b0, 1'b0);
    add(2'd1, 3, 3, 1'b0, 1'b0);
    add(2'd1, 3, 2, 1'b0, 1'b0);
    // Hold still ticks
    add(2'd3, 3, 2, 1'b0, 1'b0);

    reset    = 1'b1;
    en       = 1'b1;
    mode     = 2'd0;
    limit    = 4'd15;
    load     = 1'b0;
    load_val = '0;
    repeat (3) cyc();
    check("reset_led", led, 0);
    check("reset_tick", tick, 0);
    check("reset_wrap", wrap, 0);
    check("reset_dir", dbg_dir, 0);
    reset = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      mode  = vec[i].mode;
      limit = vec[i].limit;
      exp_q.push_back({vec[i].dir, vec[i].led, vec[i].wrap});
      wait_tick(n);
      check($sformatf("interval[%0d]", i), n, DV);
      got = exp_q.pop_front();
      check($sformatf("led[%0d]", i), led, got[W:1]);
      check($sformatf("wrap[%0d]", i), wrap, got[0]);
      check($sformatf("dir[%0d]", i), dbg_dir, got[W+1]);
    end

    // LOAD above LIMIT collides with a step: clamped, no tick, step discarded
    mode     = 2'd0;
    limit    = 4'd9;
    load_val = 4'd12;
    repeat (DV - 1) cyc();
    load = 1'b1;
    cyc();
    load = 1'b0;
    check("load_led", led, 9);
    check("load_tick", tick, 0);
    check("load_wrap", wrap, 0);
    wait_tick(n);
    check("load_next_interval", n, DV);
    check("load_next_led", led, 0);
    check("load_next_wrap", wrap, 1);

    // EN dropped with pre==2 for 7 cycles
    repeat (2) cyc();
    en  = 1'b0;
    bad = 1'b0;
    repeat (7) begin
      cyc();
      if (tick || led != 0) bad = 1'b1;
    end
    check("pause_frozen", bad, 0);
    en = 1'b1;
    wait_tick(n);
    check("resume_interval", n, 2);
    check("resume_led", led, 1);
    check("resume_wrap", wrap, 0);

    // RESET beats a simultaneous LOAD
    load_val = 4'd7;
    load     = 1'b1;
    cyc();
    load = 1'b0;
    check("preload_led", led, 7);
    reset    = 1'b1;
    load     = 1'b1;
    load_val = 4'd5;
    cyc();
    reset = 1'b0;
    load  = 1'b0;
    check("rst_load_led", led, 0);
    check("rst_load_tick", tick, 0);
    check("rst_load_wrap", wrap, 0);
    wait_tick(n);
    check("rst_resume_interval", n, DV);
    check("rst_resume_led", led, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
